redirect_hazard_unit: RTL

Pipeline redirect and hazard unit for the 5-stage DLX core. It sits in EX and produces the `branchCheck` / `JumpCheck` / `JRCheck` strobes that the ID-stage control decoder consumes to raise `IFflush` / `IDflush` / `EXflush`. Its inputs are the decoded `Branch` / `Jump` / `JR` / `MemRead` bits carried into EX, plus forwarded operands. It resolves taken branches and jumps, drives the PC redirect, detects load-use hazards, and keeps saturating redirect and stall performance counters.

---
 rtl/redirect_hazard_unit.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/redirect_hazard_unit.sv
// ---------------------------------------------------------------------------
// redirect_hazard_unit
//
// Purpose:
//   EX-stage redirect and hazard unit for the 5-stage DLX core.
//   - Resolves JR / Jump / taken Branch in EX and redirects the PC.
//     Priority among them is JR > Jump > Branch.
//   - Raises one of the strobes branchCheck / JumpCheck / JRCheck for exactly
//     one cycle. The ID-stage control decoder turns that strobe into its
//     IF/ID/EX flushes.
//   - Detects load-use hazards and stalls the front end for one cycle.
//   - Keeps saturating counters of redirects and stall cycles.
//
// Redirect sequence: IDLE (taken instruction in EX) -> FLUSH (strobe,
// redirect_valid, PC loads target) -> RECOVER (inputs ignored) -> IDLE.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ex_valid                   EX holds a real instruction
//   ex_branch/ex_jump/ex_jr    decoded control bits in EX
//   ex_opcode                  EX opcode (0x04 BEQ, 0x05 BNEZ)
//   ex_rs_val, ex_rt_val       forwarded operand values
//   ex_pc_plus4                PC+4 of the EX instruction
//   ex_imm                     sign-extended branch immediate
//   ex_joff                    J-type byte offset field
//   ex_memread, ex_rd          EX load and its destination register
//   id_rs, id_rt, id_uses_rt   source registers of the ID instruction
//   branchCheck/JumpCheck/JRCheck  registered one-cycle redirect strobes
//   redirect_valid, redirect_pc    PC redirect request and target
//   pc_write_en, ifid_write_en     PC and IF/ID register enables
//   idex_bubble                    insert a bubble into ID/EX
//   redirect_count, stall_count    saturating event counters
// ---------------------------------------------------------------------------
module redirect_hazard_unit #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic             ex_jr,
  input  logic [5:0]       ex_opcode,
  input  logic [31:0]      ex_rs_val,
  input  logic [31:0]      ex_rt_val,
  input  logic [PC_W-1:0]  ex_pc_plus4,
  input  logic [31:0]      ex_imm,
  input  logic [25:0]      ex_joff,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  output logic             branchCheck,
  output logic             JumpCheck,
  output logic             JRCheck,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] redirect_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNEZ = 6'h05;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    RECOVER
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            branch_taken;
  logic            redirect_req;
  logic            stall;
  logic [2:0]      strobe_next;
  logic [PC_W-1:0] target;
  logic [31:0]     joff_sext;

  // Branch resolution and target selection.
  // Only BEQ and BNEZ can be taken; any other opcode carrying the branch bit
  // falls through. When several control bits are set at once, JR wins, then
  // Jump, then Branch. strobe_next stays one-hot as {branch, jump, jr}.
  // The targets are built at 32 bits and truncated to PC_W, so every add
  // wraps modulo 2^PC_W.
  always_comb begin
    branch_taken = 1'b0;
    strobe_next  = 3'b000;
    target       = '0;
    joff_sext    = {{6{ex_joff[25]}}, ex_joff};

    if (ex_branch) begin
      if (ex_opcode == OP_BEQ) begin
        branch_taken = (ex_rs_val == ex_rt_val);
      end else if (ex_opcode == OP_BNEZ) begin
        branch_taken = (ex_rs_val != 32'd0);
      end
    end

    if (ex_jr) begin
      strobe_next = 3'b001;
      target      = ex_rs_val[PC_W-1:0];
    end else if (ex_jump) begin
      strobe_next = 3'b010;
      target      = ex_pc_plus4 + joff_sext[PC_W-1:0];
    end else if (branch_taken) begin
      strobe_next = 3'b100;
      target      = ex_pc_plus4 + ex_imm[PC_W-1:0];
    end
  end

  // Redirect and load-use detection.
  // Both are evaluated only in IDLE, so anything presented during FLUSH or
  // RECOVER is ignored. A redirect in the same cycle suppresses the stall,
  // because the stalled ID instruction is about to be flushed anyway.
  always_comb begin
    redirect_req = (state == IDLE) && ex_valid && (strobe_next != 3'b000);
    stall        = (state == IDLE) && !redirect_req && ex_valid && ex_memread &&
                   (ex_rd != 5'd0) &&
                   ((id_rs == ex_rd) || (id_uses_rt && (id_rt == ex_rd)));
  end

  // State register.
  // The asynchronous reset returns the unit to IDLE immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  // A redirect always takes exactly the path IDLE -> FLUSH -> RECOVER -> IDLE.
  // That fixed path keeps back-to-back redirects at least two cycles apart.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (redirect_req) state_next = FLUSH;
      FLUSH:   state_next = RECOVER;
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes and redirect target.
  // The strobes are loaded on the IDLE->FLUSH edge and cleared on every
  // other edge, so each strobe is high for exactly the FLUSH cycle. The
  // asynchronous reset drops them at once, even in the middle of FLUSH.
  // redirect_pc holds the last target until the next redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branchCheck <= 1'b0;
      JumpCheck   <= 1'b0;
      JRCheck     <= 1'b0;
      redirect_pc <= '0;
    end else begin
      branchCheck <= redirect_req && strobe_next[2];
      JumpCheck   <= redirect_req && strobe_next[1];
      JRCheck     <= redirect_req && strobe_next[0];
      if (redirect_req) begin
        redirect_pc <= target;
      end
    end
  end

  // Performance counters.
  // Each counter sticks at all-ones rather than wrapping, so a large count
  // can never read back as a small one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_count <= '0;
      stall_count    <= '0;
    end else begin
      if (redirect_req && (redirect_count != {CNT_W{1'b1}})) begin
        redirect_count <= redirect_count + 1'b1;
      end
      if (stall && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

  // Pipeline control outputs.
  // While reset is held, the PC and IF/ID are frozen and ID/EX gets a
  // bubble. FLUSH lets the PC load the target and bubbles the wrong-path
  // instruction. A load-use stall in IDLE freezes the front end for one
  // cycle. Otherwise the pipeline flows freely.
  always_comb begin
    pc_write_en    = 1'b1;
    ifid_write_en  = 1'b1;
    idex_bubble    = 1'b0;
    redirect_valid = (state == FLUSH);
    if (!rst_n) begin
      pc_write_en    = 1'b0;
      ifid_write_en  = 1'b0;
      idex_bubble    = 1'b1;
      redirect_valid = 1'b0;
    end else if (state == FLUSH) begin
      idex_bubble = 1'b1;
    end else if (stall) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      idex_bubble   = 1'b1;
    end
  end

endmodule
